// File: rtl/washing_cycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : washing_cycle_sequencer_if
// Brief    : Control/preset inputs and status outputs of the cycle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface washing_cycle_sequencer_if;
   logic       start;
   logic       pause;
   logic       abort;
   logic [4:0] wash_time;
   logic [4:0] rinse_time;
   logic [4:0] spin_time;
   logic [4:0] cloth;
   logic [2:0] state;
   logic       wash_on;
   logic       rinse_on;
   logic       spin_on;
   logic       busy;
   logic       done;
   logic       fault;
   logic [4:0] phase_remaining;
   logic [7:0] remaining;

   modport master (
      output start, pause, abort, wash_time, rinse_time, spin_time, cloth,
      input  state, wash_on, rinse_on, spin_on, busy, done, fault,
             phase_remaining, remaining
   );

   modport slave (
      input  start, pause, abort, wash_time, rinse_time, spin_time, cloth,
      output state, wash_on, rinse_on, spin_on, busy, done, fault,
             phase_remaining, remaining
   );
endinterface
`default_nettype wire

// File: rtl/washing_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : washing_cycle_sequencer
// Brief    : Runs one wash/rinse/spin cycle in minute ticks from a preset.
// Revision : 1.0 - initial release
// ============================================================================
module washing_cycle_sequencer #(
   parameter int TICK_DIV = 4,
   parameter int MAX_LOAD = 20
) (
   input  logic                      clk,
   input  logic                      rst,
   washing_cycle_sequencer_if.slave  bus
);
   localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(TICK_DIV - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WASH  = 3'd1;
   localparam logic [2:0] S_RINSE = 3'd2;
   localparam logic [2:0] S_SPIN  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       r_state,  w_state;
   logic [4:0]       r_phase,  w_phase;
   logic [7:0]       r_rem,    w_rem;
   logic [PRE_W-1:0] r_pre,    w_pre;
   logic             r_fault,  w_fault;
   logic [4:0]       r_rinse,  w_rinse;
   logic [4:0]       r_spin,   w_spin;
   logic             r_wash_on, r_rinse_on, r_spin_on, r_busy, r_done;
   logic             w_overload;

   assign w_overload = 32'(bus.cloth) > MAX_LOAD;

   always_comb begin
      w_state = r_state;
      w_phase = r_phase;
      w_rem   = r_rem;
      w_pre   = r_pre;
      w_fault = r_fault;
      w_rinse = r_rinse;
      w_spin  = r_spin;
      case (r_state)
         S_IDLE: begin
            if (bus.start && !bus.abort) begin
               if (w_overload) begin
                  w_fault = 1'b1;
               end else begin
                  w_fault = 1'b0;
                  w_rinse = bus.rinse_time;
                  w_spin  = bus.spin_time;
                  w_pre   = '0;
                  w_rem   = {3'b000, bus.wash_time} + {3'b000, bus.rinse_time}
                          + {3'b000, bus.spin_time};
                  if (bus.wash_time != 5'd0) begin
                     w_state = S_WASH;
                     w_phase = bus.wash_time;
                  end else if (bus.rinse_time != 5'd0) begin
                     w_state = S_RINSE;
                     w_phase = bus.rinse_time;
                  end else if (bus.spin_time != 5'd0) begin
                     w_state = S_SPIN;
                     w_phase = bus.spin_time;
                  end else begin
                     w_state = S_DONE;
                     w_phase = 5'd0;
                  end
               end
            end
         end
         S_WASH, S_RINSE, S_SPIN: begin
            if (bus.abort) begin
               w_state = S_IDLE;
               w_phase = 5'd0;
               w_rem   = 8'd0;
               w_pre   = '0;
            end else if (!bus.pause) begin
               if (r_pre == C_PRE_LAST) begin
                  w_pre = '0;
                  w_rem = r_rem - 8'd1;
                  // Last minute of the phase: advance past any zero-length phases.
                  if (r_phase == 5'd1) begin
                     if (r_state == S_WASH && r_rinse != 5'd0) begin
                        w_state = S_RINSE;
                        w_phase = r_rinse;
                     end else if (r_state != S_SPIN && r_spin != 5'd0) begin
                        w_state = S_SPIN;
                        w_phase = r_spin;
                     end else begin
                        w_state = S_DONE;
                        w_phase = 5'd0;
                     end
                  end else begin
                     w_phase = r_phase - 5'd1;
                  end
               end else begin
                  w_pre = r_pre + PRE_W'(1);
               end
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
            w_phase = 5'd0;
            w_rem   = 8'd0;
            w_pre   = '0;
         end
         default: begin
            w_state = S_IDLE;
            w_phase = 5'd0;
            w_rem   = 8'd0;
            w_pre   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_phase    <= 5'd0;
         r_rem      <= 8'd0;
         r_pre      <= '0;
         r_fault    <= 1'b0;
         r_rinse    <= 5'd0;
         r_spin     <= 5'd0;
         r_wash_on  <= 1'b0;
         r_rinse_on <= 1'b0;
         r_spin_on  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_phase    <= w_phase;
         r_rem      <= w_rem;
         r_pre      <= w_pre;
         r_fault    <= w_fault;
         r_rinse    <= w_rinse;
         r_spin     <= w_spin;
         r_wash_on  <= (w_state == S_WASH);
         r_rinse_on <= (w_state == S_RINSE);
         r_spin_on  <= (w_state == S_SPIN);
         r_busy     <= (w_state == S_WASH) || (w_state == S_RINSE) || (w_state == S_SPIN);
         r_done     <= (w_state == S_DONE);
      end
   end

   assign bus.state           = r_state;
   assign bus.wash_on         = r_wash_on;
   assign bus.rinse_on        = r_rinse_on;
   assign bus.spin_on         = r_spin_on;
   assign bus.busy            = r_busy;
   assign bus.done            = r_done;
   assign bus.fault           = r_fault;
   assign bus.phase_remaining = r_phase;
   assign bus.remaining       = r_rem;
endmodule
`default_nettype wire

// File: tb/tb_washing_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_washing_cycle_sequencer
// Brief    : Directed self-checking bench for washing_cycle_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_washing_cycle_sequencer;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   cyc;
   logic seen_wash, seen_spin, seen_busy, seen_done;

   washing_cycle_sequencer_if bus ();

   washing_cycle_sequencer #(
      .TICK_DIV (4),
      .MAX_LOAD (20)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge, then sample 1 ns later and accumulate "ever seen" flags.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      seen_wash = seen_wash | bus.wash_on;
      seen_spin = seen_spin | bus.spin_on;
      seen_busy = seen_busy | bus.busy;
      seen_done = seen_done | bus.done;
   endtask

   task automatic step_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic check(input string tag, input int observed, input int expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic clear_seen();
      seen_wash = 1'b0;
      seen_spin = 1'b0;
      seen_busy = 1'b0;
      seen_done = 1'b0;
   endtask

   task automatic set_preset(input int w, input int r, input int s, input int c);
      bus.wash_time  = 5'(w);
      bus.rinse_time = 5'(r);
      bus.spin_time  = 5'(s);
      bus.cloth      = 5'(c);
   endtask

   // Raise start, take edge k, drop start; cyc then counts cycles after k.
   task automatic launch();
      bus.start = 1'b1;
      cyc = 0;
      step();
      bus.start = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      clear_seen();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.abort = 1'b0;
      set_preset(0, 0, 0, 0);
      step();
      step();
      rst = 1'b0;
      check("reset_state", int'(bus.state), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_fault", int'(bus.fault), 0);
      check("reset_remaining", int'(bus.remaining), 0);
      step();

      // Normal run; preset changes after start must not matter.
      set_preset(3, 2, 1, 10);
      clear_seen();
      launch();
      set_preset(9, 9, 9, 31);
      check("norm_k1_state", int'(bus.state), 1);
      check("norm_k1_phase", int'(bus.phase_remaining), 3);
      check("norm_k1_rem", int'(bus.remaining), 6);
      check("norm_k1_busy", int'(bus.busy), 1);
      check("norm_k1_wash_on", int'(bus.wash_on), 1);
      step_to(12);
      check("norm_k12_state", int'(bus.state), 1);
      check("norm_k12_phase", int'(bus.phase_remaining), 1);
      step_to(13);
      check("norm_k13_state", int'(bus.state), 2);
      check("norm_k13_phase", int'(bus.phase_remaining), 2);
      check("norm_k13_rem", int'(bus.remaining), 3);
      step_to(21);
      check("norm_k21_state", int'(bus.state), 3);
      check("norm_k21_phase", int'(bus.phase_remaining), 1);
      step_to(24);
      check("norm_k24_done", int'(bus.done), 0);
      step_to(25);
      check("norm_k25_state", int'(bus.state), 4);
      check("norm_k25_done", int'(bus.done), 1);
      check("norm_k25_rem", int'(bus.remaining), 0);
      check("norm_k25_busy", int'(bus.busy), 0);
      step_to(26);
      check("norm_k26_state", int'(bus.state), 0);
      check("norm_k26_done", int'(bus.done), 0);

      // Zero-length wash and spin are skipped.
      set_preset(0, 2, 0, 5);
      clear_seen();
      launch();
      check("zero_k1_state", int'(bus.state), 2);
      check("zero_k1_phase", int'(bus.phase_remaining), 2);
      check("zero_k1_rem", int'(bus.remaining), 2);
      step_to(8);
      check("zero_k8_state", int'(bus.state), 2);
      step_to(9);
      check("zero_k9_state", int'(bus.state), 4);
      step_to(10);
      check("zero_k10_state", int'(bus.state), 0);
      check("zero_wash_never", int'(seen_wash), 0);
      check("zero_spin_never", int'(seen_spin), 0);

      // All phases zero: straight to DONE.
      set_preset(0, 0, 0, 5);
      clear_seen();
      launch();
      check("allz_k1_state", int'(bus.state), 4);
      check("allz_k1_done", int'(bus.done), 1);
      step_to(2);
      check("allz_k2_state", int'(bus.state), 0);
      check("allz_busy_never", int'(seen_busy), 0);

      // Pause for 5 cycles during WASH.
      set_preset(3, 2, 1, 10);
      launch();
      step_to(2);
      bus.pause = 1'b1;
      step_to(7);
      check("pause_hold_state", int'(bus.state), 1);
      check("pause_hold_phase", int'(bus.phase_remaining), 3);
      check("pause_hold_rem", int'(bus.remaining), 6);
      check("pause_hold_wash_on", int'(bus.wash_on), 1);
      bus.pause = 1'b0;
      step_to(17);
      check("pause_k17_state", int'(bus.state), 1);
      step_to(18);
      check("pause_k18_state", int'(bus.state), 2);
      step_to(29);
      check("pause_k29_state", int'(bus.state), 3);
      step_to(30);
      check("pause_k30_done", int'(bus.done), 1);
      step_to(31);

      // Abort in RINSE, then rerun the same preset.
      launch();
      clear_seen();
      step_to(14);
      check("abort_pre_state", int'(bus.state), 2);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check("abort_state", int'(bus.state), 0);
      check("abort_rem", int'(bus.remaining), 0);
      check("abort_phase", int'(bus.phase_remaining), 0);
      check("abort_rinse_on", int'(bus.rinse_on), 0);
      step();
      step();
      check("abort_no_done", int'(seen_done), 0);
      launch();
      check("rerun_k1_state", int'(bus.state), 1);
      check("rerun_k1_rem", int'(bus.remaining), 6);
      step_to(24);
      check("rerun_k24_state", int'(bus.state), 3);
      step_to(25);
      check("rerun_k25_done", int'(bus.done), 1);
      step_to(26);

      // Overload refuses start; MAX_LOAD itself is accepted.
      set_preset(3, 2, 1, 21);
      launch();
      check("ovl_fault", int'(bus.fault), 1);
      check("ovl_state", int'(bus.state), 0);
      step();
      check("ovl_stays_idle", int'(bus.state), 0);
      set_preset(3, 2, 1, 20);
      launch();
      check("max_fault_clear", int'(bus.fault), 0);
      check("max_state", int'(bus.state), 1);
      step_to(22);
      check("rst_pre_state", int'(bus.state), 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_state", int'(bus.state), 0);
      check("rst_spin_on", int'(bus.spin_on), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_rem", int'(bus.remaining), 0);
      check("rst_phase", int'(bus.phase_remaining), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/washing_cycle_sequencer.md
# washing_cycle_sequencer

Downstream consumer of the preset register bank: takes the selected preset's wash, rinse, spin and cloth values and runs one washing cycle through its timed phases. Phase durations are snapshotted at start; the block then counts them down in minute ticks and drives the phase-enable outputs, remaining-time displays, and a completion pulse. An overload check on the cloth value gates the start.

## Interface
- TICK_DIV, 4: clock cycles per one-minute tick (≥2).
- MAX_LOAD, 20: largest accepted cloth value; a larger value refuses start.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled start request; honoured only in IDLE.
- pause  in  1  while high in a running phase, freezes all counters.
- abort  in  1  cancels a running cycle.
- wash_time  in  5  wash minutes (preset wash_out).
- rinse_time  in  5  rinse minutes (preset rinse_out).
- spin_time  in  5  spin minutes (preset spin_out).
- cloth  in  5  load weight (preset cloth_out).
- state  out  3  IDLE=0, WASH=1, RINSE=2, SPIN=3, DONE=4.
- wash_on, rinse_on, spin_on  out  1 each  high exactly while in the matching state.
- busy  out  1  high in WASH, RINSE or SPIN.
- done  out  1  one-cycle pulse, high only in DONE.
- fault  out  1  overload flag.
- phase_remaining  out  5  minutes left in current phase.
- remaining  out  8  minutes left in the whole cycle.

## Operation
- Reset: state=IDLE; all outputs 0; latched times, prescaler, counters cleared.
- IDLE, start=1, abort=0:
  - cloth>MAX_LOAD: fault←1, stay IDLE, nothing latched.
  - otherwise: fault←0; latch wash/rinse/spin; remaining←wash+rinse+spin (zero-extended to 8 bits, max 93, no overflow); enter the first non-zero phase in order WASH→RINSE→SPIN with phase_remaining←that phase's time. All three zero: go straight to DONE.
- start held high through a cycle restarts only after returning to IDLE, i.e. level-sensitive; start while busy or DONE is ignored.
- Running phase: a prescaler counts 0..TICK_DIV-1 while pause=0. Prescaler is cleared on every phase entry. At prescaler=TICK_DIV-1 a tick occurs: prescaler wraps to 0, phase_remaining and remaining decrement by 1.
- Tick with phase_remaining=1: next state is the next non-zero phase (its time loaded into phase_remaining), skipping zero phases. If none remain, DONE.
- DONE: done=1 for one cycle; phase_remaining=0, remaining=0; next state IDLE.
- pause=1 while running: prescaler, phase_remaining, remaining, state all hold. Enable outputs stay asserted. pause is ignored in IDLE/DONE.
- abort=1 in a running phase or DONE: next cycle IDLE, counters and enables cleared, no done pulse; fault unchanged.
- Priority: rst > abort > pause > tick/start.
- Inputs wash_time..cloth are only sampled at the accepted start; mid-cycle changes (preset reselection) have no effect.

## Timing
- All outputs registered; state and counters update on the rising clk edge.
- Accepted start sampled at edge k: at k+1 state=first phase, busy=1.
- Phase of T minutes with no pause lasts exactly T×TICK_DIV cycles. Each pause cycle extends it by one.
- Last phase ends → DONE for one cycle → IDLE. For total time S and no pause, DONE is at k+1+S×TICK_DIV.
- An overload start sets fault at k+1; state never leaves IDLE.
- rst asserted mid-cycle: IDLE and all-zero outputs on the next edge.

## Test plan
- Normal run (TICK_DIV=4), wash=3, rinse=2, spin=1, cloth=10, start at k:
  - k+1: WASH, phase_remaining=3, remaining=6.
  - k+13: RINSE, phase_remaining=2.
  - k+21: SPIN.
  - k+25: DONE with done=1.
  - k+26: IDLE.
- Zero skip, wash=0, rinse=2, spin=0: k+1 RINSE, k+9 DONE; wash_on and spin_on never assert.
- All zero times: DONE at k+1, IDLE at k+2, busy never 1.
- Pause, same as normal run with pause high for 5 cycles during WASH: counters frozen during the pause; DONE at k+30.
- Abort in RINSE: next cycle IDLE, remaining=0, no done pulse. A following start with the same values reruns the full 24-cycle cycle.
- Overload, cloth=21: fault=1 at k+1, state stays 0. A following start with cloth=20 clears fault and enters WASH. rst mid-SPIN gives all outputs 0 on the next cycle.
